// File: rtl/mmio_router.sv
// mmio_router: single-master MMIO address router.
//   Decodes cpu_addr[SEL_HI:SEL_LO] against NSLV region IDs and forwards the
//   request to one slave. The slave select is one-hot and is held until that
//   slave acks. Unmapped accesses complete with cpu_err and do not touch any
//   slave. Each completion produces a single-cycle cpu_ready pulse.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cpu_req/we/addr/wdata           CPU request (sampled in IDLE only)
//   cpu_rdata/ready/err             CPU response (rdata/err hold until next RESP)
//   s_sel/s_we/s_addr/s_wdata       slave request (registered)
//   s_rdata/s_ack                   packed slave read data, per-slave ack
// Optional: define MMIO_ROUTER_TIMEOUT_EN to add an ACCESS watchdog that
//   completes with cpu_err after TIMEOUT_CYCLES cycles without an ack.
module mmio_router #(
  parameter int NSLV           = 4,
  parameter int SEL_HI         = 31,
  parameter int SEL_LO         = 20,
  parameter logic [NSLV*(SEL_HI-SEL_LO+1)-1:0] REGION_IDS =
    {12'h004, 12'h003, 12'h002, 12'h001},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_err,
  output logic [NSLV-1:0]    s_sel,
  output logic               s_we,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  input  logic [NSLV*32-1:0] s_rdata,
  input  logic [NSLV-1:0]    s_ack
);

  localparam int W = SEL_HI - SEL_LO + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [NSLV-1:0] s_sel_q, s_sel_d;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d;
  logic            cpu_err_q, cpu_err_d;

  // Region decode: per-slot compare, then keep only the lowest matching slot.
  logic [W-1:0]    region;
  logic [NSLV-1:0] slot_hit, hit_sel, one_v;

  assign region = cpu_addr[SEL_HI:SEL_LO];
  assign one_v  = NSLV'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_slot
      assign slot_hit[gi] = (REGION_IDS[gi*W +: W] == region);
    end
  endgenerate

  // x & -x isolates the lowest set bit.
  assign hit_sel = slot_hit & (~slot_hit + one_v);

  // Only the selected slave's ack/data matter; others are masked off.
  logic        ack_hit;
  logic [31:0] sel_rdata;

  assign ack_hit = |(s_ack & s_sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++)
      sel_rdata = sel_rdata | ({32{s_sel_q[i]}} & s_rdata[i*32 +: 32]);
  end

  logic timeout;

`ifdef MMIO_ROUTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;

  // wdog_q counts completed ACCESS cycles, so the current cycle is number
  // wdog_q+1; the access is abandoned at the end of cycle TIMEOUT_CYCLES.
  assign timeout = (state_q == ACCESS) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if (state_q == ACCESS) wdog_d = wdog_q + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    s_sel_d     = s_sel_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = cpu_err_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_d = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
          if (|hit_sel) begin
            s_sel_d = hit_sel;
            state_d = ACCESS;
          end else begin
            s_sel_d     = '0;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = '0;
            state_d     = RESP;
          end
        end
      end
      ACCESS: begin
        // Ack takes priority over a coincident timeout.
        if (ack_hit) begin
          cpu_rdata_d = req_q.we ? 32'h0 : sel_rdata;
          cpu_err_d   = 1'b0;
          s_sel_d     = '0;
          state_d     = RESP;
        end else if (timeout) begin
          cpu_rdata_d = '0;
          cpu_err_d   = 1'b1;
          s_sel_d     = '0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      s_sel_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      s_sel_q     <= s_sel_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  assign cpu_ready = (state_q == RESP);
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;
  assign s_sel     = s_sel_q;
  assign s_we      = req_q.we;
  assign s_addr    = req_q.addr;
  assign s_wdata   = req_q.wdata;

endmodule

// File: tb/tb_mmio_router.sv
module tb_mmio_router;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_req2, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [31:0]  cpu_rdata, cpu_rdata2;
  logic         cpu_ready, cpu_ready2, cpu_err, cpu_err2;
  logic [3:0]   s_sel, s_sel2, s_ack, s_ack2;
  logic         s_we, s_we2;
  logic [31:0]  s_addr, s_addr2, s_wdata, s_wdata2;
  logic [127:0] s_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_router #(.NSLV(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  // Slots 1 and 2 share region 0x002: lowest index must win.
  mmio_router #(.NSLV(4), .TIMEOUT_CYCLES(8),
                .REGION_IDS({12'h004, 12'h002, 12'h002, 12'h001})) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req2), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata2), .cpu_ready(cpu_ready2), .cpu_err(cpu_err2),
    .s_sel(s_sel2), .s_we(s_we2), .s_addr(s_addr2), .s_wdata(s_wdata2),
    .s_rdata(s_rdata), .s_ack(s_ack2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; cpu_req = 0; cpu_req2 = 0; cpu_we = 0;
    cpu_addr = 0; cpu_wdata = 0; s_ack = 0; s_ack2 = 0;
    s_rdata = {32'h4444_4444, 32'hCAFE_0002, 32'h1234_5678, 32'hDEAD_BEEF};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sel",   s_sel, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_err",   cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_addr",  s_addr, 0);
    chk("rst_we",    s_we, 0);
    chk("rst_wdata", s_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read slot0, immediate ack
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0010_0004; s_ack = 4'b0001;
    @(negedge clk);
    chk("t1_sel",    s_sel, 4'b0001);
    chk("t1_addr",   s_addr, 32'h0010_0004);
    chk("t1_we",     s_we, 0);
    chk("t1_nrdy",   cpu_ready, 0);
    @(negedge clk);
    chk("t1_rdy",    cpu_ready, 1);
    chk("t1_rdata",  cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_err",    cpu_err, 0);
    chk("t1_seloff", s_sel, 0);
    cpu_req = 0; s_ack = 0;
    @(negedge clk);
    chk("t1_rdy_end",  cpu_ready, 0);
    chk("t1_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Write slot1, ack in 4th ACCESS cycle; unselected acks asserted throughout
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0020_0000; cpu_wdata = 32'h41; s_ack = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_sel",  s_sel, 4'b0010);
      chk("t2_nrdy", cpu_ready, 0);
    end
    chk("t2_we",    s_we, 1);
    chk("t2_wdata", s_wdata, 32'h41);
    @(negedge clk);
    chk("t2_sel4",  s_sel, 4'b0010);
    chk("t2_nrdy4", cpu_ready, 0);
    s_ack = 4'b0010;
    @(negedge clk);
    chk("t2_rdy",   cpu_ready, 1);
    chk("t2_err",   cpu_err, 0);
    chk("t2_rdata", cpu_rdata, 0);
    chk("t2_seloff", s_sel, 0);
    cpu_req = 0; s_ack = 0; cpu_we = 0;
    @(negedge clk);
    chk("t2_single", cpu_ready, 0);

    // Unmapped read
    cpu_req = 1; cpu_addr = 32'h0050_0000;
    @(negedge clk);
    chk("t3_sel",   s_sel, 0);
    chk("t3_rdy",   cpu_ready, 1);
    chk("t3_err",   cpu_err, 1);
    chk("t3_rdata", cpu_rdata, 0);
    cpu_req = 0;
    @(negedge clk);
    chk("t3_rdy_end",  cpu_ready, 0);
    chk("t3_err_hold", cpu_err, 1);

    // Slot2 never acks
    cpu_req = 1; cpu_addr = 32'h0030_0000; s_ack = 0;
`ifdef MMIO_ROUTER_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t4_sel",  s_sel, 4'b0100);
      chk("t4_nrdy", cpu_ready, 0);
    end
    @(negedge clk);
    chk("t4_to_rdy",   cpu_ready, 1);
    chk("t4_to_err",   cpu_err, 1);
    chk("t4_to_rdata", cpu_rdata, 0);
    chk("t4_to_sel",   s_sel, 0);
`else
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (cpu_ready) seen++;
    end
    chk("t4_no_ready", seen, 0);
    chk("t4_sel_held", s_sel, 4'b0100);
    s_ack = 4'b0100;
    @(negedge clk);
    chk("t4_rdy",   cpu_ready, 1);
    chk("t4_err",   cpu_err, 0);
    chk("t4_rdata", cpu_rdata, 32'hCAFE_0002);
`endif
    cpu_req = 0; s_ack = 0;
    @(negedge clk);

    // Reset in ACCESS on slot3, late ack
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0040_0000; cpu_wdata = 32'h55;
    @(negedge clk);
    chk("t5_sel", s_sel, 4'b1000);
    rst_n = 0; cpu_req = 0; s_ack = 4'b1000;
    #1;
    chk("t5_rst_sel",   s_sel, 0);
    chk("t5_rst_we",    s_we, 0);
    chk("t5_rst_addr",  s_addr, 0);
    chk("t5_rst_wdata", s_wdata, 0);
    chk("t5_rst_rdata", cpu_rdata, 0);
    chk("t5_rst_rdy",   cpu_ready, 0);
    chk("t5_rst_err",   cpu_err, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t5_late_rdy", cpu_ready, 0);
      chk("t5_late_sel", s_sel, 0);
    end
    s_ack = 0; cpu_we = 0;
    cpu_req = 1; cpu_addr = 32'h0010_0008; s_ack = 4'b0001;
    @(negedge clk);
    chk("t5_next_sel", s_sel, 4'b0001);
    @(negedge clk);
    chk("t5_next_rdy",   cpu_ready, 1);
    chk("t5_next_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t5_next_err",   cpu_err, 0);
    cpu_req = 0; s_ack = 0;
    @(negedge clk);

    // Overlapping region IDs on dut2
    cpu_req2 = 1; cpu_addr = 32'h0020_0000; s_ack2 = 0;
    @(negedge clk);
    chk("t6_sel", s_sel2, 4'b0010);
    s_ack2 = 4'b0110;
    @(negedge clk);
    chk("t6_rdy",   cpu_ready2, 1);
    chk("t6_rdata", cpu_rdata2, 32'h1234_5678);
    chk("t6_err",   cpu_err2, 0);
    cpu_req2 = 0; s_ack2 = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_router.md
MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 Parameter NSLV, default 4, SHALL set the number of slave ports (1..8).
REQ-002 Parameter SEL_HI, default 31, and SEL_LO, default 20, SHALL select the address field cpu_addr[SEL_HI:SEL_LO] that is decoded as the region ID.
REQ-003 Parameter REGION_IDS, default {12'h004,12'h003,12'h002,12'h001}, SHALL hold NSLV packed region IDs; slot i occupies bits [i*W+W-1:i*W], with W=SEL_HI-SEL_LO+1.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the watchdog limit in clk cycles.
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 cpu_req  in  1  transaction request, sampled in IDLE only.
REQ-008 cpu_we  in  1  1=write, 0=read.
REQ-009 cpu_addr  in  32  byte address.
REQ-010 cpu_wdata  in  32  write data.
REQ-011 cpu_rdata  out  32  registered read data, valid while cpu_ready=1.
REQ-012 cpu_ready  out  1  one-cycle completion pulse.
REQ-013 cpu_err  out  1  qualifies cpu_ready: unmapped access or timeout.
REQ-014 s_sel  out  NSLV  one-hot slave select, held for the whole access.
REQ-015 s_we, s_addr, s_wdata  out  1/32/32  registered copies of the CPU request.
REQ-016 s_rdata  in  NSLV*32  packed slave read data; slot i is [i*32+31:i*32].
REQ-017 s_ack  in  NSLV  slave completion; a slave SHALL consume or pop side effects (keyboard FIFO pop) only in its ack cycle.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP.
REQ-019 IDLE with cpu_req=1 SHALL latch we/addr/wdata into s_we/s_addr/s_wdata and decode the region in that same cycle.
REQ-020 Hit on slot i: next state ACCESS, s_sel=1<<i; with multiple matching slots, the lowest index SHALL win.
REQ-021 Miss: next state RESP with cpu_err=1, cpu_rdata=0, s_sel=0; no slave is touched.
REQ-022 ACCESS: s_sel held; on s_ack[i]=1 for the selected i, capture s_rdata slot i (reads; writes capture 0), drop s_sel, go to RESP.
REQ-023 s_ack bits of unselected slaves SHALL be ignored.
REQ-024 RESP: cpu_ready=1 for exactly one cycle, then IDLE; minimum latency req->ready is 2 cycles with a same-cycle ack.
REQ-025 cpu_req asserted outside IDLE SHALL be ignored; the CPU SHALL hold its request until cpu_ready.
REQ-026 cpu_rdata and cpu_err SHALL hold their values until the next RESP.

Reset
REQ-027 rst_n=0 SHALL force IDLE, s_sel=0, s_we=0, s_addr=0, s_wdata=0, cpu_rdata=0, cpu_ready=0, cpu_err=0, watchdog=0 immediately.
REQ-028 Reset during ACCESS SHALL abort the access without a cpu_ready pulse; a late s_ack after reset SHALL be ignored.

Configuration
REQ-029 Macro MMIO_ROUTER_TIMEOUT_EN defined: a watchdog SHALL count cycles in ACCESS, cleared on entry; at count==TIMEOUT_CYCLES with no ack, go to RESP with cpu_err=1, cpu_rdata=0, s_sel=0.
REQ-030 Ack and timeout in the same cycle: the ack SHALL win (normal completion, cpu_err=0).
REQ-031 Macro undefined: no watchdog logic; ACCESS SHALL wait indefinitely for s_ack.

Verification
REQ-032 Read 0x0010_0004, slot0 acks at once with 0xDEADBEEF -> s_sel=0001 for 1 cycle, cpu_ready 2 cycles after req, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-033 Write 0x0020_0000 data 0x41, slot1 acks after 3 cycles -> s_sel=0010 for 4 cycles, s_we=1, s_wdata=0x41, single cpu_ready, cpu_err=0.
REQ-034 Read 0x0050_0000 (unmapped) -> s_sel stays 0, cpu_ready with cpu_err=1 and cpu_rdata=0.
REQ-035 Read 0x0030_0000, slot2 never acks, TIMEOUT_CYCLES=8, macro defined -> cpu_err=1 after 8 ACCESS cycles; macro undefined -> no cpu_ready for 100 cycles.
REQ-036 rst_n pulsed low during ACCESS on slot3, slot3 acks 1 cycle later -> no cpu_ready, all outputs 0, next req serviced normally.
REQ-037 REGION_IDS with slots 1 and 2 both 0x002, access 0x0020_0000 -> s_sel=0010 only.
